// File: rtl/fila_pkg.sv
// fila_pkg
// Shared types and constants for the queue-draining serializer.
//   estado_ser_t : serializer FSM states
//   BITS_DADO    : data bits per serial frame
//   LINHA_OCIOSA : idle level of the serial line
package fila_pkg;

    localparam int   BITS_DADO    = 8;
    localparam logic LINHA_OCIOSA = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ESPERA,
        CARGA,
        START,
        DADOS,
        PARIDADE_BIT,
        STOP
    } estado_ser_t;

endpackage

// File: rtl/fila_serializador_gerador_tick.sv
// gerador_tick
// Bit-time counter. Counts 0..CICLOS_POR_BIT-1 and flags the last count.
//   clk_10KHz : system clock
//   reset     : synchronous active-high reset
//   clear     : synchronous restart of the count at 0
//   tick      : high during the last cycle of a bit time
module gerador_tick #(
    parameter int CICLOS_POR_BIT = 10
) (
    input  logic clk_10KHz,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] ULTIMO = 8'(CICLOS_POR_BIT - 1);

    logic [7:0] contagem;

    always_ff @(posedge clk_10KHz) begin
        if (reset || clear) begin
            contagem <= '0;
        end else if (tick) begin
            contagem <= '0;
        end else begin
            contagem <= contagem + 8'd1;
        end
    end

    assign tick = (contagem == ULTIMO);

endmodule

// File: rtl/fila_serializador.sv
// fila_serializador
// Drains the 8-entry byte queue and sends each byte as an async serial
// frame: start bit, 8 data bits LSB first, optional even parity, stop bit.
//   clk_10KHz      : system clock
//   reset          : synchronous active-high reset
//   enable_in      : allows a new byte to be requested (checked in IDLE only)
//   len_in         : queue occupancy
//   data_in        : queue head byte
//   dequeue_out    : one-cycle dequeue request to the queue
//   tx_out         : serial line, idles high
//   busy_out       : high whenever the FSM is not in IDLE
//   byte_count_out : frames completed since reset (wraps)
//   last_byte_out  : most recently loaded byte
//
// state        | meaning
// IDLE         | line high, waiting for enable_in and a non-empty queue
// REQ          | queue samples the dequeue request
// ESPERA       | queue head valid, queue pops on this edge
// CARGA        | head byte captured into the shift register
// START        | start bit (low)
// DADOS        | data bits, LSB first
// PARIDADE_BIT | even parity bit (only when PARIDADE=1)
// STOP         | stop bit (high), frame counted on its last cycle
module fila_serializador
    import fila_pkg::*;
#(
    parameter int CICLOS_POR_BIT = 10,
    parameter bit PARIDADE       = 1'b0
) (
    input  logic       clk_10KHz,
    input  logic       reset,
    input  logic       enable_in,
    input  logic [7:0] len_in,
    input  logic [7:0] data_in,
    output logic       dequeue_out,
    output logic       tx_out,
    output logic       busy_out,
    output logic [7:0] byte_count_out,
    output logic [7:0] last_byte_out
);

    estado_ser_t          estado, estado_prox;
    logic [BITS_DADO-1:0] desloc;
    logic                 paridade;
    logic [2:0]           indice, indice_prox;
    logic                 tx_prox;
    logic                 deq_prox;
    logic                 tick;
    logic                 limpa_tick;

    // Restarting the bit timer on every state change makes each state
    // last exactly one bit time regardless of how long IDLE was.
    assign limpa_tick = (estado_prox != estado);

    gerador_tick #(
        .CICLOS_POR_BIT(CICLOS_POR_BIT)
    ) u_tick (
        .clk_10KHz(clk_10KHz),
        .reset    (reset),
        .clear    (limpa_tick),
        .tick     (tick)
    );

    always_comb begin
        estado_prox = estado;
        indice_prox = indice;
        deq_prox    = 1'b0;
        case (estado)
            IDLE: begin
                if (enable_in && (len_in != 8'd0)) begin
                    estado_prox = REQ;
                    deq_prox    = 1'b1;
                end
            end
            REQ:    estado_prox = ESPERA;
            ESPERA: estado_prox = CARGA;
            CARGA:  estado_prox = START;
            START: begin
                if (tick) begin
                    estado_prox = DADOS;
                    indice_prox = 3'd0;
                end
            end
            DADOS: begin
                if (tick) begin
                    if (indice == 3'(BITS_DADO - 1)) begin
                        estado_prox = PARIDADE ? PARIDADE_BIT : STOP;
                    end else begin
                        indice_prox = indice + 3'd1;
                    end
                end
            end
            PARIDADE_BIT: begin
                if (tick) estado_prox = STOP;
            end
            STOP: begin
                if (tick) estado_prox = IDLE;
            end
            default: estado_prox = IDLE;
        endcase
    end

    // The line level is chosen from the state being entered so the
    // registered tx_out changes on the same edge as the state.
    always_comb begin
        tx_prox = LINHA_OCIOSA;
        case (estado_prox)
            START:        tx_prox = 1'b0;
            DADOS:        tx_prox = desloc[indice_prox];
            PARIDADE_BIT: tx_prox = paridade;
            default:      tx_prox = LINHA_OCIOSA;
        endcase
    end

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            estado         <= IDLE;
            indice         <= 3'd0;
            tx_out         <= LINHA_OCIOSA;
            dequeue_out    <= 1'b0;
            byte_count_out <= 8'd0;
            last_byte_out  <= 8'd0;
            desloc         <= '0;
            paridade       <= 1'b0;
        end else begin
            estado      <= estado_prox;
            indice      <= indice_prox;
            tx_out      <= tx_prox;
            dequeue_out <= deq_prox;
            if (estado == CARGA) begin
                desloc        <= data_in;
                last_byte_out <= data_in;
                paridade      <= ^data_in;
            end
            if ((estado == STOP) && tick) begin
                byte_count_out <= byte_count_out + 8'd1;
            end
        end
    end

    assign busy_out = (estado != IDLE);

endmodule

// File: tb/tb_fila_serializador.sv
// tb_fila_serializador
// Bench for fila_serializador: a behavioural queue feeds the main instance
// (10 cycles/bit, no parity) and a frame decoder checks every transmitted
// byte against a scoreboard. A second instance (4 cycles/bit, parity on)
// is driven directly for the parity frames.
module tb_fila_serializador;

    localparam int N0 = 10;
    localparam int N1 = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] len0 = 8'd0, dat0 = 8'd0, len1 = 8'd0, dat1 = 8'd0;
    logic       deq0, tx0, busy0, deq1, tx1, busy1;
    logic [7:0] cnt0, last0, cnt1, last1;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] fila[$];
    logic [7:0] exp_q[$];
    int pop_cd   = 0;
    int n_deq    = 0;
    int ncyc     = 0;
    int last_deq = 0;
    int n_frames = 0;
    logic mon_abort = 1'b0;

    always #5 clk = ~clk;

    fila_serializador #(.CICLOS_POR_BIT(N0), .PARIDADE(1'b0)) dut0 (
        .clk_10KHz(clk), .reset(rst), .enable_in(en),
        .len_in(len0), .data_in(dat0), .dequeue_out(deq0), .tx_out(tx0),
        .busy_out(busy0), .byte_count_out(cnt0), .last_byte_out(last0)
    );

    fila_serializador #(.CICLOS_POR_BIT(N1), .PARIDADE(1'b1)) dut1 (
        .clk_10KHz(clk), .reset(rst), .enable_in(en),
        .len_in(len1), .data_in(dat1), .dequeue_out(deq1), .tx_out(tx1),
        .busy_out(busy1), .byte_count_out(cnt1), .last_byte_out(last1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic upd_q();
        len0 = 8'(fila.size());
        dat0 = (fila.size() > 0) ? fila[0] : 8'h00;
    endtask

    task automatic push0(input logic [7:0] b);
        fila.push_back(b);
        exp_q.push_back(b);
        upd_q();
    endtask

    // Queue model: samples the request, pops two edges later (after the
    // serializer has captured the head byte).
    always @(negedge clk) begin
        ncyc++;
        if (pop_cd > 0) begin
            pop_cd--;
            if (pop_cd == 0 && fila.size() > 0) begin
                void'(fila.pop_front());
                upd_q();
            end
        end
        if (deq0 === 1'b1) begin
            if (n_deq > 0) check_val("deq_gap", 32'(ncyc - last_deq >= 3), 1);
            n_deq++;
            last_deq = ncyc;
            pop_cd   = 3;
        end
    end

    task automatic mon_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
        end
    endtask

    // Frame decoder for the main instance, samples mid-bit.
    initial begin : mon0
        logic [7:0] b;
        logic [7:0] e;
        logic       s;
        logic       stp;
        forever begin
            @(negedge clk);
            if (!rst && tx0 === 1'b0) begin
                mon_abort = 1'b0;
                mon_wait(N0 / 2);
                s = tx0;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(N0);
                    b[i] = tx0;
                end
                mon_wait(N0);
                stp = tx0;
                if (mon_abort) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else if (exp_q.size() == 0) begin
                    check_val("sb_underflow", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("frame_byte", b, e);
                    check_val("start_bit", s, 0);
                    check_val("stop_bit", stp, 1);
                    n_frames++;
                end
            end
        end
    end

    initial begin
        int k;
        int j;
        int r;
        int base_deq;
        int base_fr;
        logic [7:0] pb;
        logic [7:0] rb;
        logic       pexp;
        logic       pbit;
        logic       pstop;

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tx", tx0, 1);
        check_val("rst_deq", deq0, 0);
        check_val("rst_busy", busy0, 0);
        check_val("rst_count", cnt0, 0);
        check_val("rst_last", last0, 0);

        // Empty queue with enable: nothing happens
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_val("idle", {tx0, deq0, busy0}, 3'b100);
        end

        // Single byte 0xA5
        push0(8'hA5);
        k = 0;
        while (deq0 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check_val("deq_seen", deq0, 1);
        @(negedge clk);
        j = 1;
        check_val("deq_pulse", deq0, 0);
        while (tx0 === 1'b1 && j < 20) begin @(negedge clk); j++; end
        // 3 cycles after the pulse = 4 cycles after the issuing IDLE cycle
        check_val("start_latency", j, 3);
        r = 0;
        while (tx0 === 1'b0 && r < 50) begin @(negedge clk); r++; end
        check_val("start_len", r, N0);
        r = 0;
        while (tx0 === 1'b1 && r < 50) begin @(negedge clk); r++; end
        check_val("bit0_len", r, N0);
        k = 0;
        while (busy0 === 1'b1 && k < 200) begin @(negedge clk); k++; end
        check_val("frame_end", busy0, 0);
        check_val("single_count", cnt0, 1);
        check_val("single_last", last0, 8'hA5);
        check_val("single_frames", n_frames, 1);

        // Full queue drain
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst2_count", cnt0, 0);
        rst = 1'b0;
        base_deq = n_deq;
        base_fr  = n_frames;
        for (int i = 1; i <= 8; i++) push0(8'(i));
        k = 0;
        while (n_frames - base_fr < 8 && k < 3000) begin @(negedge clk); k++; end
        check_val("drain_frames", n_frames - base_fr, 8);
        k = 0;
        while (busy0 === 1'b1 && k < 200) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        check_val("drain_deqs", n_deq - base_deq, 8);
        check_val("drain_len", len0, 0);
        check_val("drain_count", cnt0, 8);

        // Enable dropped mid-frame
        base_deq = n_deq;
        base_fr  = n_frames;
        push0(8'h11);
        push0(8'h22);
        push0(8'h33);
        repeat (30) @(negedge clk);
        en = 1'b0;
        k = 0;
        while (busy0 === 1'b1 && k < 300) begin @(negedge clk); k++; end
        repeat (50) @(negedge clk);
        check_val("en_busy", busy0, 0);
        check_val("en_deqs", n_deq - base_deq, 1);
        check_val("en_len", len0, 2);
        check_val("en_frames", n_frames - base_fr, 1);
        en = 1'b1;
        k = 0;
        while (n_frames - base_fr < 3 && k < 1000) begin @(negedge clk); k++; end
        check_val("resume_frames", n_frames - base_fr, 3);
        repeat (10) @(negedge clk);
        check_val("resume_len", len0, 0);
        check_val("resume_count", cnt0, 11);

        // Reset during data bit 4
        push0(8'h00);
        k = 0;
        while (deq0 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check_val("rst_deq_seen", deq0, 1);
        j = 0;
        while (tx0 === 1'b1 && j < 20) begin @(negedge clk); j++; end
        repeat (5 * N0 + N0 / 2) @(negedge clk);
        check_val("pre_reset_tx", tx0, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_tx", tx0, 1);
        check_val("abort_busy", busy0, 0);
        check_val("abort_count", cnt0, 0);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check_val("post_abort_count", cnt0, 0);
        check_val("post_abort_tx", tx0, 1);
        check_val("post_abort_busy", busy0, 0);

        // Parity instance: 0x07 -> parity 1, 0x03 -> parity 0
        for (int t = 0; t < 2; t++) begin
            pb   = (t == 0) ? 8'h07 : 8'h03;
            pexp = (t == 0) ? 1'b1 : 1'b0;
            dat1 = pb;
            len1 = 8'd1;
            k = 0;
            while (deq1 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            check_val("par_deq_seen", deq1, 1);
            len1 = 8'd0;
            j = 0;
            while (tx1 === 1'b1 && j < 20) begin @(negedge clk); j++; end
            repeat (N1 / 2) @(negedge clk);
            check_val("par_start", tx1, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (N1) @(negedge clk);
                rb[i] = tx1;
            end
            repeat (N1) @(negedge clk);
            pbit = tx1;
            repeat (N1) @(negedge clk);
            pstop = tx1;
            k = 0;
            while (busy1 === 1'b1 && k < 20) begin @(negedge clk); k++; end
            check_val("par_byte", rb, pb);
            check_val("par_bit", pbit, pexp);
            check_val("par_stop", pstop, 1);
            check_val("par_frame_tail", k, N1 / 2);
            repeat (3) @(negedge clk);
        end
        check_val("par_count", cnt1, 2);
        check_val("par_last", last1, 8'h03);

        check_val("sb_left", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
